// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/writeback pipeline stage.
// Captures execute-stage outputs and resolves conditional branches.
// Runs the single-outstanding data-memory handshake, stalling upstream until
// the access is acked, and drives the register-file write port.
// Optional feature: define MEM_BUS_TIMEOUT_EN to abort accesses left un-acked
// for TIMEOUT_CYCLES cycles. An aborted access pulses busErr_o and skips writeback.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic                clk,
  input  logic                rst,
  // execute-stage outputs
  input  logic                valid_i,
  input  logic                flush_i,
  input  logic                wdSrc_i,
  input  logic                regWrite_i,
  input  logic                branch_i,
  input  logic                condZero_i,
  input  logic                bge_i,
  input  logic                aluZero_i,
  input  logic                aluNeg_i,
  input  logic [31:0]         aluResult_i,
  input  logic [4:0]          rd_i,
  input  logic [31:0]         immU_i,
  input  logic [31:0]         pcBranch_i,
  input  logic                memRead_i,
  input  logic                memWrite_i,
  input  logic [31:0]         storeData_i,
  // pipeline control
  output logic                stall_o,
  output logic                pcSrc_o,
  output logic [31:0]         pcBranch_o,
  // register-file write port
  output logic                regWrite_o,
  output logic [4:0]          rd_o,
  output logic [31:0]         wd_o,
  // data-memory bus
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [31:0]         dmem_addr_o,
  output logic [31:0]         dmem_wdata_o,
  input  logic [31:0]         dmem_rdata_i,
  input  logic                dmem_ack_i,
  output logic                busErr_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } stateT;

  stateT             state;

  // stage registers
  logic              validR;
  logic              wdSrcR;
  logic              regWriteR;
  logic              branchR;
  logic              condZeroR;
  logic              bgeR;
  logic              aluZeroR;
  logic              aluNegR;
  logic [XLEN-1:0]   aluResultR;
  logic [REG_W-1:0]  rdR;
  logic [XLEN-1:0]   immUR;
  logic [XLEN-1:0]   pcBranchR;
  logic              memReadR;
  logic              memWriteR;
  logic [XLEN-1:0]   storeDataR;

  logic              pending;
  logic              capture;
  logic              abortAcc;
  logic              memAck;
  logic              isMem;
  logic              branchTaken;
  logic              nextIsMem;

  assign pending   = (state == PEND);
  assign memAck    = pending & dmem_ack_i;
  assign nextIsMem = valid_i & ~flush_i & (memRead_i | memWrite_i);

`ifdef MEM_BUS_TIMEOUT_EN
  logic [CNT_W-1:0]  toCnt;

  // Abort on the last permitted un-acked cycle of an access.
  assign abortAcc = pending & ~dmem_ack_i & (toCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Timeout counter: cleared whenever the stage captures, counts stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toCnt <= '0;
    end else if (capture) begin
      toCnt <= '0;
    end else begin
      toCnt <= toCnt + CNT_W'(1);
    end
  end
`else
  assign abortAcc = 1'b0;
`endif

  // An un-acked, un-aborted access holds the whole upstream pipeline.
  assign stall_o = pending & ~dmem_ack_i & ~abortAcc;
  assign capture = ~stall_o;

  // Stage registers: load execute outputs whenever not stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validR     <= 1'b0;
      wdSrcR     <= 1'b0;
      regWriteR  <= 1'b0;
      branchR    <= 1'b0;
      condZeroR  <= 1'b0;
      bgeR       <= 1'b0;
      aluZeroR   <= 1'b0;
      aluNegR    <= 1'b0;
      aluResultR <= '0;
      rdR        <= '0;
      immUR      <= '0;
      pcBranchR  <= '0;
      memReadR   <= 1'b0;
      memWriteR  <= 1'b0;
      storeDataR <= '0;
    end else if (capture) begin
      validR     <= valid_i & ~flush_i;
      wdSrcR     <= wdSrc_i;
      regWriteR  <= regWrite_i;
      branchR    <= branch_i;
      condZeroR  <= condZero_i;
      bgeR       <= bge_i;
      aluZeroR   <= aluZero_i;
      aluNegR    <= aluNeg_i;
      aluResultR <= aluResult_i;
      rdR        <= rd_i;
      immUR      <= immU_i;
      pcBranchR  <= pcBranch_i;
      memReadR   <= memRead_i;
      memWriteR  <= memWrite_i;
      storeDataR <= storeData_i;
    end
  end

  // Bus FSM: a captured load/store opens an access that lasts until ack or abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (capture) begin
      state <= nextIsMem ? PEND : IDLE;
    end
  end

  // Branch resolution, bus drive and writeback selection from the stage registers.
  always_comb begin
    isMem        = validR & (memReadR | memWriteR);
    branchTaken  = bgeR ? ~aluNegR : (aluZeroR == condZeroR);

    pcSrc_o      = validR & branchR & branchTaken;
    pcBranch_o   = validR ? pcBranchR : '0;

    dmem_req_o   = pending & ~abortAcc;
    dmem_we_o    = dmem_req_o & memWriteR;
    dmem_addr_o  = dmem_req_o ? aluResultR : '0;
    dmem_wdata_o = (dmem_req_o & memWriteR) ? storeDataR : '0;

    rd_o         = validR ? rdR : '0;
    regWrite_o   = 1'b0;
    wd_o         = '0;
    if (isMem) begin
      // Loads write back only in the ack cycle; stores never write back.
      regWrite_o = memReadR & ~memWriteR & regWriteR & memAck;
      wd_o       = (memReadR & pending) ? dmem_rdata_i : '0;
    end else if (validR) begin
      regWrite_o = regWriteR;
      wd_o       = wdSrcR ? immUR : aluResultR;
    end

    busErr_o     = abortAcc;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scenarios plus a randomized run against a
// behavioural model of the memory/writeback stage.
module tb_mem_wb_stage;

  localparam int unsigned TO = 4;

  typedef struct {
    logic        valid;
    logic        flush;
    logic        wdSrc;
    logic        regWrite;
    logic        branch;
    logic        condZero;
    logic        bge;
    logic        aluZero;
    logic        aluNeg;
    logic [31:0] aluResult;
    logic [4:0]  rd;
    logic [31:0] immU;
    logic [31:0] pcBranch;
    logic        memRead;
    logic        memWrite;
    logic [31:0] storeData;
  } instT;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, flush_i, wdSrc_i, regWrite_i, branch_i, condZero_i, bge_i;
  logic        aluZero_i, aluNeg_i, memRead_i, memWrite_i, dmem_ack_i;
  logic [31:0] aluResult_i, immU_i, pcBranch_i, storeData_i, dmem_rdata_i;
  logic [4:0]  rd_i;
  logic        stall_o, pcSrc_o, regWrite_o, dmem_req_o, dmem_we_o, busErr_o;
  logic [31:0] pcBranch_o, wd_o, dmem_addr_o, dmem_wdata_o;
  logic [4:0]  rd_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .flush_i(flush_i), .wdSrc_i(wdSrc_i), .regWrite_i(regWrite_i),
    .branch_i(branch_i), .condZero_i(condZero_i), .bge_i(bge_i),
    .aluZero_i(aluZero_i), .aluNeg_i(aluNeg_i), .aluResult_i(aluResult_i),
    .rd_i(rd_i), .immU_i(immU_i), .pcBranch_i(pcBranch_i),
    .memRead_i(memRead_i), .memWrite_i(memWrite_i), .storeData_i(storeData_i),
    .stall_o(stall_o), .pcSrc_o(pcSrc_o), .pcBranch_o(pcBranch_o),
    .regWrite_o(regWrite_o), .rd_o(rd_o), .wd_o(wd_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .busErr_o(busErr_o)
  );

  function automatic instT bubble();
    instT t;
    t = '{default: '0};
    return t;
  endfunction

  function automatic instT mkAlu(input logic [31:0] res, input logic [4:0] rd,
                                 input logic wdSrc, input logic [31:0] immU);
    instT t = bubble();
    t.valid = 1'b1; t.regWrite = 1'b1; t.aluResult = res; t.rd = rd;
    t.wdSrc = wdSrc; t.immU = immU;
    return t;
  endfunction

  function automatic instT mkBranch(input logic bge, input logic az, input logic cz,
                                    input logic neg, input logic [31:0] target);
    instT t = bubble();
    t.valid = 1'b1; t.branch = 1'b1; t.bge = bge; t.aluZero = az;
    t.condZero = cz; t.aluNeg = neg; t.pcBranch = target;
    return t;
  endfunction

  function automatic instT mkLoad(input logic [31:0] addr, input logic [4:0] rd);
    instT t = bubble();
    t.valid = 1'b1; t.memRead = 1'b1; t.regWrite = 1'b1; t.aluResult = addr; t.rd = rd;
    return t;
  endfunction

  function automatic instT mkStore(input logic [31:0] addr, input logic [31:0] data);
    instT t = bubble();
    t.valid = 1'b1; t.memWrite = 1'b1; t.aluResult = addr; t.storeData = data;
    return t;
  endfunction

  function automatic instT randInst();
    instT t;
    int   kind;
    t.valid = ($urandom_range(0, 9) < 8); t.flush = ($urandom_range(0, 9) == 0);
    t.wdSrc = 1'($urandom); t.regWrite = 1'($urandom); t.branch = 1'b0;
    t.condZero = 1'($urandom); t.bge = 1'($urandom);
    t.aluZero = 1'($urandom); t.aluNeg = 1'($urandom);
    t.aluResult = $urandom; t.rd = 5'($urandom); t.immU = $urandom;
    t.pcBranch = $urandom; t.storeData = $urandom;
    t.memRead = 1'b0; t.memWrite = 1'b0;
    kind = $urandom_range(0, 3);
    if (kind == 1) t.branch = 1'b1;
    if (kind == 2) begin t.memRead = 1'b1; t.regWrite = 1'b1; end
    if (kind == 3) t.memWrite = 1'b1;
    return t;
  endfunction

  task automatic drive(input instT t);
    valid_i = t.valid; flush_i = t.flush; wdSrc_i = t.wdSrc; regWrite_i = t.regWrite;
    branch_i = t.branch; condZero_i = t.condZero; bge_i = t.bge;
    aluZero_i = t.aluZero; aluNeg_i = t.aluNeg; aluResult_i = t.aluResult;
    rd_i = t.rd; immU_i = t.immU; pcBranch_i = t.pcBranch;
    memRead_i = t.memRead; memWrite_i = t.memWrite; storeData_i = t.storeData;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    drive(mkLoad(32'h100, 5'd1));
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", dmem_req_o); end
    checks++; if (regWrite_o !== 1'b0) begin errors++; $display("FAIL reset_regWrite got=%b exp=0", regWrite_o); end
    checks++; if (wd_o !== 32'h0) begin errors++; $display("FAIL reset_wd got=%h exp=0", wd_o); end
    checks++; if (pcSrc_o !== 1'b0 || busErr_o !== 1'b0 || rd_o !== 5'd0)
      begin errors++; $display("FAIL reset_misc pcSrc=%b busErr=%b rd=%0d exp 0", pcSrc_o, busErr_o, rd_o); end
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack_i = 1'b0; drive(bubble());
  endtask

  task automatic test_reset_pend();
    instT t = mkLoad(32'h200, 5'd6);
    t.branch = 1'b1; t.aluZero = 1'b1; t.condZero = 1'b1;
    drive(t); nextCycle(); drive(bubble());
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b1 || stall_o !== 1'b1 || pcSrc_o !== 1'b1)
      begin errors++; $display("FAIL pend_pre_rst req=%b stall=%b pcSrc=%b exp 1 1 1", dmem_req_o, stall_o, pcSrc_o); end
    #1; rst = 1'b1; #1;
    checks++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0)
      begin errors++; $display("FAIL async_rst_bus req=%b stall=%b exp 0 0", dmem_req_o, stall_o); end
    checks++; if (regWrite_o !== 1'b0 || pcSrc_o !== 1'b0)
      begin errors++; $display("FAIL async_rst_wb regWrite=%b pcSrc=%b exp 0 0", regWrite_o, pcSrc_o); end
    nextCycle(); rst = 1'b0; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || regWrite_o !== 1'b0)
      begin errors++; $display("FAIL post_rst_idle req=%b stall=%b regWrite=%b exp 0 0 0", dmem_req_o, stall_o, regWrite_o); end
    nextCycle(); dmem_ack_i = 1'b0;
  endtask

  task automatic test_alu();
    drive(mkAlu(32'h2A, 5'd5, 1'b0, 32'hAAAA_0000)); nextCycle();
    drive(mkAlu(32'h99, 5'd7, 1'b1, 32'h1234_5000)); dmem_ack_i = 1'b1; dmem_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++; if (regWrite_o !== 1'b1) begin errors++; $display("FAIL addi_regWrite got=%b exp=1", regWrite_o); end
    checks++; if (rd_o !== 5'd5) begin errors++; $display("FAIL addi_rd got=%0d exp=5", rd_o); end
    checks++; if (wd_o !== 32'h2A) begin errors++; $display("FAIL addi_wd got=%h exp=2a", wd_o); end
    checks++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b0)
      begin errors++; $display("FAIL addi_idle_ack stall=%b req=%b exp 0 0", stall_o, dmem_req_o); end
    nextCycle(); dmem_ack_i = 1'b0;
    drive(mkAlu(32'h5, 5'd8, 1'b0, 32'h0)); flush_i = 1'b1;
    @(negedge clk);
    checks++; if (wd_o !== 32'h1234_5000 || rd_o !== 5'd7)
      begin errors++; $display("FAIL lui_wd got=%h rd=%0d exp=12345000 rd=7", wd_o, rd_o); end
    nextCycle(); drive(bubble());
    @(negedge clk);
    checks++; if (regWrite_o !== 1'b0) begin errors++; $display("FAIL flushed_regWrite got=%b exp=0", regWrite_o); end
    nextCycle();
  endtask

  task automatic test_branch();
    drive(mkBranch(1'b0, 1'b1, 1'b1, 1'b0, 32'h40)); nextCycle();
    drive(mkBranch(1'b0, 1'b0, 1'b1, 1'b0, 32'h40));
    @(negedge clk);
    checks++; if (pcSrc_o !== 1'b1 || pcBranch_o !== 32'h40)
      begin errors++; $display("FAIL beq_taken pcSrc=%b tgt=%h exp 1 40", pcSrc_o, pcBranch_o); end
    checks++; if (regWrite_o !== 1'b0) begin errors++; $display("FAIL beq_regWrite got=%b exp=0", regWrite_o); end
    nextCycle(); drive(mkBranch(1'b1, 1'b0, 1'b0, 1'b1, 32'h60));
    @(negedge clk);
    checks++; if (pcSrc_o !== 1'b0) begin errors++; $display("FAIL beq_not_taken got=%b exp=0", pcSrc_o); end
    nextCycle(); drive(mkBranch(1'b1, 1'b1, 1'b0, 1'b0, 32'h80));
    @(negedge clk);
    checks++; if (pcSrc_o !== 1'b0) begin errors++; $display("FAIL bge_neg got=%b exp=0", pcSrc_o); end
    nextCycle(); drive(bubble());
    @(negedge clk);
    checks++; if (pcSrc_o !== 1'b1 || pcBranch_o !== 32'h80)
      begin errors++; $display("FAIL bge_taken pcSrc=%b tgt=%h exp 1 80", pcSrc_o, pcBranch_o); end
    nextCycle();
  endtask

  task automatic test_load_wait();
    drive(mkLoad(32'h100, 5'd9)); nextCycle();
    drive(mkAlu(32'h11, 5'd4, 1'b0, 32'h0)); dmem_rdata_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      dmem_ack_i = (i == 3);
      @(negedge clk);
      checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_addr_o !== 32'h100)
        begin errors++; $display("FAIL lw_bus c%0d req=%b we=%b addr=%h exp 1 0 100", i, dmem_req_o, dmem_we_o, dmem_addr_o); end
      checks++; if (stall_o !== (i < 3)) begin errors++; $display("FAIL lw_stall c%0d got=%b exp=%b", i, stall_o, (i < 3)); end
      checks++; if (regWrite_o !== (i == 3)) begin errors++; $display("FAIL lw_regWrite c%0d got=%b exp=%b", i, regWrite_o, (i == 3)); end
      if (i == 3) begin
        checks++; if (wd_o !== 32'hDEAD_BEEF || rd_o !== 5'd9)
          begin errors++; $display("FAIL lw_wd got=%h rd=%0d exp=deadbeef rd=9", wd_o, rd_o); end
      end
      nextCycle();
    end
    dmem_ack_i = 1'b0; drive(bubble());
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b0 || regWrite_o !== 1'b1 || rd_o !== 5'd4 || wd_o !== 32'h11)
      begin errors++; $display("FAIL lw_next req=%b regWrite=%b rd=%0d wd=%h exp 0 1 4 11", dmem_req_o, regWrite_o, rd_o, wd_o); end
    nextCycle();
  endtask

  task automatic test_back_to_back();
    drive(mkStore(32'h8, 32'h55)); nextCycle();
    drive(mkAlu(32'h77, 5'd3, 1'b0, 32'h0)); dmem_ack_i = 1'b1;
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || dmem_addr_o !== 32'h8 || dmem_wdata_o !== 32'h55)
      begin errors++; $display("FAIL sw_bus req=%b we=%b addr=%h wdata=%h exp 1 1 8 55", dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o); end
    checks++; if (stall_o !== 1'b0 || regWrite_o !== 1'b0)
      begin errors++; $display("FAIL sw_ctrl stall=%b regWrite=%b exp 0 0", stall_o, regWrite_o); end
    nextCycle(); dmem_ack_i = 1'b0; drive(bubble());
    @(negedge clk);
    checks++; if (regWrite_o !== 1'b1 || rd_o !== 5'd3 || wd_o !== 32'h77)
      begin errors++; $display("FAIL sw_next regWrite=%b rd=%0d wd=%h exp 1 3 77", regWrite_o, rd_o, wd_o); end
    nextCycle();
  endtask

  task automatic test_timeout();
    drive(mkLoad(32'h300, 5'd12)); nextCycle(); drive(bubble()); dmem_ack_i = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge clk);
      checks++; if (stall_o !== (i < int'(TO) - 1)) begin errors++; $display("FAIL to_stall c%0d got=%b", i, stall_o); end
      checks++; if (busErr_o !== (i == int'(TO) - 1)) begin errors++; $display("FAIL to_busErr c%0d got=%b", i, busErr_o); end
      checks++; if (dmem_req_o !== (i < int'(TO) - 1) || regWrite_o !== 1'b0)
        begin errors++; $display("FAIL to_req c%0d req=%b regWrite=%b", i, dmem_req_o, regWrite_o); end
      nextCycle();
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (busErr_o !== 1'b0 || regWrite_o !== 1'b0 || stall_o !== 1'b0)
      begin errors++; $display("FAIL to_late_ack busErr=%b regWrite=%b stall=%b exp 0 0 0", busErr_o, regWrite_o, stall_o); end
    nextCycle(); dmem_ack_i = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 4) begin
        checks++; if (stall_o !== 1'b1 || dmem_req_o !== 1'b1 || busErr_o !== 1'b0)
          begin errors++; $display("FAIL nto_wait c%0d stall=%b req=%b busErr=%b exp 1 1 0", i, stall_o, dmem_req_o, busErr_o); end
      end
      nextCycle();
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (regWrite_o !== 1'b1 || wd_o !== 32'hCAFE_F00D || stall_o !== 1'b0)
      begin errors++; $display("FAIL nto_ack regWrite=%b wd=%h stall=%b exp 1 cafef00d 0", regWrite_o, wd_o, stall_o); end
    nextCycle(); dmem_ack_i = 1'b0;
`endif
  endtask

  task automatic test_random();
    instT        cur;
    instT        nxt;
    logic        curValid;
    int          waitCnt;
    logic        memOp, abortExp, expStall, expReq, expWe, expRw, expPc;
    logic [31:0] expWd;
    rst = 1'b1; drive(bubble()); dmem_ack_i = 1'b0;
    nextCycle(); rst = 1'b0;
    cur = bubble(); curValid = 1'b0; waitCnt = 0;
    for (int n = 0; n < 600; n++) begin
      nxt = randInst(); drive(nxt);
      dmem_ack_i = ($urandom_range(0, 9) < 4); dmem_rdata_i = $urandom;
      memOp    = curValid & (cur.memRead | cur.memWrite);
`ifdef MEM_BUS_TIMEOUT_EN
      abortExp = memOp & ~dmem_ack_i & (waitCnt == int'(TO) - 1);
`else
      abortExp = 1'b0;
`endif
      expReq   = memOp & ~abortExp;
      expStall = memOp & ~dmem_ack_i & ~abortExp;
      expWe    = cur.memWrite;
      expRw    = memOp ? (cur.memRead & dmem_ack_i) : (curValid & cur.regWrite);
      expWd    = cur.memRead ? dmem_rdata_i : (cur.wdSrc ? cur.immU : cur.aluResult);
      expPc    = curValid & cur.branch & (cur.bge ? ~cur.aluNeg : (cur.aluZero == cur.condZero));
      @(negedge clk);
      checks++; if (stall_o !== expStall) begin errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall_o, expStall); end
      checks++; if (dmem_req_o !== expReq) begin errors++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, dmem_req_o, expReq); end
      checks++; if (busErr_o !== abortExp) begin errors++; $display("FAIL rnd_busErr n=%0d got=%b exp=%b", n, busErr_o, abortExp); end
      checks++; if (regWrite_o !== expRw) begin errors++; $display("FAIL rnd_regWrite n=%0d got=%b exp=%b", n, regWrite_o, expRw); end
      checks++; if (pcSrc_o !== expPc) begin errors++; $display("FAIL rnd_pcSrc n=%0d got=%b exp=%b", n, pcSrc_o, expPc); end
      if (expReq) begin
        checks++; if (dmem_we_o !== expWe || dmem_addr_o !== cur.aluResult)
          begin errors++; $display("FAIL rnd_bus n=%0d we=%b addr=%h exp %b %h", n, dmem_we_o, dmem_addr_o, expWe, cur.aluResult); end
        if (expWe) begin
          checks++; if (dmem_wdata_o !== cur.storeData)
            begin errors++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, dmem_wdata_o, cur.storeData); end
        end
      end
      if (expRw) begin
        checks++; if (wd_o !== expWd || rd_o !== cur.rd)
          begin errors++; $display("FAIL rnd_wb n=%0d wd=%h rd=%0d exp %h %0d", n, wd_o, rd_o, expWd, cur.rd); end
      end
      if (expPc) begin
        checks++; if (pcBranch_o !== cur.pcBranch)
          begin errors++; $display("FAIL rnd_target n=%0d got=%h exp=%h", n, pcBranch_o, cur.pcBranch); end
      end
      @(posedge clk);
      if (!expStall) begin
        cur = nxt; curValid = nxt.valid & ~nxt.flush; waitCnt = 0;
      end else begin
        waitCnt++;
      end
      #1;
    end
    dmem_ack_i = 1'b0; drive(bubble());
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load_wait();
    test_back_to_back();
    test_timeout();
    test_reset_pend();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
